day_advance_ctrl: RTL and testbench

Parametrised day-of-week counter for the alarm clock time chain. Advances when the enable and the full cascade of lower-stage thresholds (sec/min/hour rollover) are met, or on a rising edge of the increment push. Adds push decrement, direct load, wrap indication and alarm-day matching. Registered outputs feed the display and alarm compare logic.

---
 rtl/day_pkg.sv | 44 ++++
 rtl/rise_edge_det.sv | 31 +++
 rtl/day_advance_ctrl.sv | 120 ++++++++++++
 tb/tb_day_advance_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/day_pkg.sv
// -----------------------------------------------------------------------------
// day_pkg
// Purpose : shared types and helpers for the day-of-week stage of the alarm
//           clock time chain.
// Contents: DAYS_PER_WEEK, weekday_e enum, day_idx_t (default-width day index),
//           day_next / day_prev wrap helpers (width-agnostic, int based so a
//           parametrised caller can cast back to its own index width).
// -----------------------------------------------------------------------------
package day_pkg;

  localparam int unsigned DAYS_PER_WEEK = 7;
  localparam int unsigned DAY_W_DEF     = 3;

  typedef enum logic [DAY_W_DEF-1:0] {
    SUN = 3'd0,
    MON = 3'd1,
    TUE = 3'd2,
    WED = 3'd3,
    THU = 3'd4,
    FRI = 3'd5,
    SAT = 3'd6
  } weekday_e;

  typedef logic [DAY_W_DEF-1:0] day_idx_t;

  // Forward step with wrap n_days-1 -> 0
  function automatic int unsigned day_next(input int unsigned d,
                                           input int unsigned n_days);
    return (d == n_days - 1) ? 0 : d + 1;
  endfunction

  // Backward step with wrap 0 -> n_days-1
  function automatic int unsigned day_prev(input int unsigned d,
                                           input int unsigned n_days);
    return (d == 0) ? n_days - 1 : d - 1;
  endfunction

  // True when a forward step from d wraps the week
  function automatic logic day_wraps(input int unsigned d,
                                     input int unsigned n_days);
    return (d == n_days - 1);
  endfunction

endpackage : day_pkg

// File: rtl/rise_edge_det.sv
// -----------------------------------------------------------------------------
// rise_edge_det
// Purpose : rising-edge detector on an already synchronised, debounced level.
//           History resets to 1 so a level held high through reset yields no
//           pulse until it is released and asserted again.
// Ports   : clk       in  system clock
//           reset     in  asynchronous active-high reset
//           i_level   in  input level
//           o_pulse_c out combinational pulse: i_level & ~previous level
// -----------------------------------------------------------------------------
module rise_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_pulse_c
);

  logic r_prev;

  // Level history, updated every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_pulse_c = i_level & ~r_prev;

endmodule : rise_edge_det

// File: rtl/day_advance_ctrl.sv
// -----------------------------------------------------------------------------
// day_advance_ctrl
// Purpose : day-of-week counter of the alarm clock time chain. Advances on the
//           cascade carry (enable & all lower-stage thresholds) or on a rising
//           edge of the increment button; decrement button, direct load, wrap
//           pulse and alarm-day match.
// Ports   : clk            in  system clock
//           reset          in  asynchronous active-high reset
//           enable         in  cascade enable from the time base
//           thresh         in  [N_THRESH] lower-stage threshold flags
//           push_increment in  increment button level
//           push_decrement in  decrement button level
//           set_valid      in  one-cycle load qualifier for set_day
//           set_day        in  [DAY_W] value to load
//           alarm_day_mask in  [N_DAYS] per-day alarm enable
//           day            out [DAY_W] current day index (registered)
//           day_enable     out pulse: day advanced (registered)
//           week_wrap      out pulse: forward wrap N_DAYS-1 -> 0 (registered)
//           set_err        out pulse: set_day out of range, load ignored
//           day_match      out alarm_day_mask[day] (combinational from day)
// Notes   : one action per cycle, priority load > forward > backward. A load
//           coincident with a carry swallows the carry; the time base must not
//           load at a rollover.
// -----------------------------------------------------------------------------
module day_advance_ctrl
  import day_pkg::*;
#(
  parameter int unsigned N_THRESH  = 3,
  parameter int unsigned N_DAYS    = DAYS_PER_WEEK,
  parameter int unsigned DAY_W     = DAY_W_DEF,
  parameter int unsigned DAY_RESET = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [N_THRESH-1:0] thresh,
  input  logic                push_increment,
  input  logic                push_decrement,
  input  logic                set_valid,
  input  logic [DAY_W-1:0]    set_day,
  input  logic [N_DAYS-1:0]   alarm_day_mask,
  output logic [DAY_W-1:0]    day,
  output logic                day_enable,
  output logic                week_wrap,
  output logic                set_err,
  output logic                day_match
);

  // Mask widened to the full index range so any DAY_W index is in bounds
  localparam int unsigned MASK_W = 1 << DAY_W;

  logic [DAY_W-1:0]  r_day;
  logic              r_day_enable;
  logic              r_week_wrap;
  logic              r_set_err;

  logic              w_carry;
  logic              w_inc_evt;
  logic              w_dec_evt;
  logic              w_fwd;
  logic              w_set_ok;
  logic [MASK_W-1:0] w_mask_ext;

  // Button edge detectors
  rise_edge_det u_inc_edge (
    .clk       (clk),
    .reset     (reset),
    .i_level   (push_increment),
    .o_pulse_c (w_inc_evt)
  );

  rise_edge_det u_dec_edge (
    .clk       (clk),
    .reset     (reset),
    .i_level   (push_decrement),
    .o_pulse_c (w_dec_evt)
  );

  // Rollover carry from the lower stages; carry and button merge into one step
  assign w_carry  = enable & (&thresh);
  assign w_fwd    = w_carry | w_inc_evt;
  assign w_set_ok = (32'(set_day) < N_DAYS);

  // Day register and pulse outputs; pulses default low every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_day        <= DAY_W'(DAY_RESET);
      r_day_enable <= 1'b0;
      r_week_wrap  <= 1'b0;
      r_set_err    <= 1'b0;
    end else begin
      r_day_enable <= 1'b0;
      r_week_wrap  <= 1'b0;
      r_set_err    <= 1'b0;
      if (set_valid) begin
        if (w_set_ok) begin
          r_day <= set_day;
        end else begin
          r_set_err <= 1'b1;
        end
      end else if (w_fwd) begin
        r_day        <= DAY_W'(day_next(32'(r_day), N_DAYS));
        r_day_enable <= 1'b1;
        r_week_wrap  <= day_wraps(32'(r_day), N_DAYS);
      end else if (w_dec_evt) begin
        // inc_evt already routed to the forward branch, so this is dec only
        r_day <= DAY_W'(day_prev(32'(r_day), N_DAYS));
      end
    end
  end

  assign w_mask_ext = MASK_W'(alarm_day_mask);

  assign day        = r_day;
  assign day_enable = r_day_enable;
  assign week_wrap  = r_week_wrap;
  assign set_err    = r_set_err;
  assign day_match  = w_mask_ext[r_day];

endmodule : day_advance_ctrl

// File: tb/tb_day_advance_ctrl.sv
module tb_day_advance_ctrl;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] thresh;
  logic       push_increment;
  logic       push_decrement;
  logic       set_valid;
  logic [2:0] set_day;
  logic [6:0] alarm_day_mask;
  logic [2:0] day;
  logic       day_enable;
  logic       week_wrap;
  logic       set_err;
  logic       day_match;

  typedef struct {
    logic [2:0] day;
    logic       en;
    logic       wrap;
    logic       err;
    logic       match;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  day_advance_ctrl #(
    .N_THRESH (3),
    .N_DAYS   (7),
    .DAY_W    (3),
    .DAY_RESET(0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .thresh        (thresh),
    .push_increment(push_increment),
    .push_decrement(push_decrement),
    .set_valid     (set_valid),
    .set_day       (set_day),
    .alarm_day_mask(alarm_day_mask),
    .day           (day),
    .day_enable    (day_enable),
    .week_wrap     (week_wrap),
    .set_err       (set_err),
    .day_match     (day_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input logic rst_i, input logic inc_i, input logic dec_i,
                      input logic en_i, input logic [2:0] th_i,
                      input logic sv_i, input logic [2:0] sd_i,
                      input logic [2:0] eday, input logic een,
                      input logic ewrap, input logic eerr);
    exp_t e;
    @(negedge clk);
    reset          = rst_i;
    push_increment = inc_i;
    push_decrement = dec_i;
    enable         = en_i;
    thresh         = th_i;
    set_valid      = sv_i;
    set_day        = sd_i;
    e.day   = eday;
    e.en    = een;
    e.wrap  = ewrap;
    e.err   = eerr;
    e.match = alarm_day_mask[eday];
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Scoreboard monitor: compare registered outputs just after each edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("day",        int'(day),        int'(mon_e.day));
      chk("day_enable", int'(day_enable), int'(mon_e.en));
      chk("week_wrap",  int'(week_wrap),  int'(mon_e.wrap));
      chk("set_err",    int'(set_err),    int'(mon_e.err));
      chk("day_match",  int'(day_match),  int'(mon_e.match));
    end
  end

  // Reset must act without waiting for a clock edge
  always @(posedge reset) begin
    #1;
    chk("async_rst_day",   int'(day),        0);
    chk("async_rst_en",    int'(day_enable), 0);
    chk("async_rst_wrap",  int'(week_wrap),  0);
    chk("async_rst_match", int'(day_match),  int'(alarm_day_mask[0]));
  end

  initial begin
    reset          = 1'b1;
    push_increment = 1'b1;
    push_decrement = 1'b0;
    enable         = 1'b0;
    thresh         = 3'b000;
    set_valid      = 1'b0;
    set_day        = 3'd0;
    alarm_day_mask = 7'b1010101;

    // 1: increment held through reset gives no event until re-pressed
    step(1, 1, 0, 0, 3'b000, 0, 3'd0, 3'd0, 0, 0, 0);
    step(1, 1, 0, 0, 3'b000, 0, 3'd0, 3'd0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 0, 3'b000, 0, 3'd0, 3'd0, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 3'd0, 3'd0, 0, 0, 0);
    step(0, 1, 0, 0, 3'b000, 0, 3'd0, 3'd1, 1, 0, 0);
    step(0, 1, 0, 0, 3'b000, 0, 3'd0, 3'd1, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 3'd0, 3'd1, 0, 0, 0);

    // 2: carry at day 6 wraps; partial thresholds do nothing; held carry steps
    step(0, 0, 0, 0, 3'b000, 1, 3'd6, 3'd6, 0, 0, 0);
    step(0, 0, 0, 1, 3'b111, 0, 3'd0, 3'd0, 1, 1, 0);
    step(0, 0, 0, 0, 3'b111, 0, 3'd0, 3'd0, 0, 0, 0);
    step(0, 0, 0, 1, 3'b101, 0, 3'd0, 3'd0, 0, 0, 0);
    step(0, 0, 0, 1, 3'b111, 0, 3'd0, 3'd1, 1, 0, 0);
    step(0, 0, 0, 1, 3'b111, 0, 3'd0, 3'd2, 1, 0, 0);

    // 3: carry and increment edge together advance once
    step(0, 1, 0, 1, 3'b111, 0, 3'd0, 3'd3, 1, 0, 0);
    step(0, 1, 0, 0, 3'b000, 0, 3'd0, 3'd3, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 3'd0, 3'd3, 0, 0, 0);

    // 4: decrement wraps backward silently; inc+dec together goes forward
    step(0, 0, 0, 0, 3'b000, 1, 3'd0, 3'd0, 0, 0, 0);
    step(0, 0, 1, 0, 3'b000, 0, 3'd0, 3'd6, 0, 0, 0);
    step(0, 0, 1, 0, 3'b000, 0, 3'd0, 3'd6, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 3'd0, 3'd6, 0, 0, 0);
    step(0, 0, 1, 0, 3'b000, 0, 3'd0, 3'd5, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 1, 3'd4, 3'd4, 0, 0, 0);
    step(0, 1, 1, 0, 3'b000, 0, 3'd0, 3'd5, 1, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 3'd0, 3'd5, 0, 0, 0);

    // 5: loads, out-of-range load, load beating a carry
    step(0, 0, 0, 0, 3'b000, 1, 3'd1, 3'd1, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 1, 3'd5, 3'd5, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 1, 3'd7, 3'd5, 0, 0, 1);
    step(0, 0, 0, 0, 3'b000, 0, 3'd0, 3'd5, 0, 0, 0);
    step(0, 0, 0, 1, 3'b111, 1, 3'd3, 3'd3, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 3'd0, 3'd3, 0, 0, 0);

    // 6: alarm mask sweep, then reset in the middle of a carry run
    alarm_day_mask = 7'b0100010;
    step(0, 0, 0, 0, 3'b000, 1, 3'd0, 3'd0, 0, 0, 0);
    for (int d = 1; d < 7; d++)
      step(0, 0, 0, 1, 3'b111, 0, 3'd0, 3'(d), 1, 0, 0);
    step(0, 0, 0, 1, 3'b111, 0, 3'd0, 3'd0, 1, 1, 0);
    step(0, 0, 0, 1, 3'b111, 0, 3'd0, 3'd1, 1, 0, 0);
    step(0, 0, 0, 1, 3'b111, 0, 3'd0, 3'd2, 1, 0, 0);
    step(1, 0, 0, 1, 3'b111, 0, 3'd0, 3'd0, 0, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 3'd0, 3'd0, 0, 0, 0);
    step(0, 0, 0, 1, 3'b111, 0, 3'd0, 3'd1, 1, 0, 0);
    step(0, 0, 0, 0, 3'b000, 0, 3'd0, 3'd1, 0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_day_advance_ctrl
